// File: rtl/pipelined_carry_adder.sv
// -----------------------------------------------------------------------------
// pipelined_carry_adder
//
// Purpose:
//   WIDTH-bit adder with carry-in and carry-out. The carry chain is split into
//   STAGES registered slices of SW = WIDTH/STAGES bits. Operands and results
//   move through the pipe under a valid/ready handshake at full throughput.
//
//   Data flow:
//   - Stage k adds slice k of the operands plus the carry registered by
//     stage k-1. Stage 0 uses cin.
//   - The operand slices that are still unused move down a shift register.
//     Each slice therefore reaches its stage in the same cycle as its carry.
//   - Completed slices enter a result shift register from the top. All
//     slices of one operation leave the last stage together.
//
// Parameters:
//   WIDTH   operand/sum width in bits (must be a multiple of STAGES)
//   STAGES  pipeline depth; latency is exactly STAGES cycles
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   a, b, cin valid this cycle
//   in_ready   out  operands accepted this cycle (combinational from advance)
//   a, b       in   WIDTH-bit operands
//   cin        in   carry into bit 0
//   out_valid  out  sum/cout (and ovf) valid
//   out_ready  in   consumer accepts the result
//   sum        out  a + b + cin modulo 2^WIDTH
//   cout       out  carry out of bit WIDTH-1
//   ovf        out  signed overflow flag (only with PIPELINED_CARRY_ADDER_OVF_EN)
//
// Build option:
//   PIPELINED_CARRY_ADDER_OVF_EN - adds the ovf output. The flag is derived in
//   the final stage from the operand MSBs, which already arrive there in the
//   top operand slice. It needs no extra delay flops.
// -----------------------------------------------------------------------------
module pipelined_carry_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SW = WIDTH / STAGES;

    // Per-stage registers. The operand registers keep the slices that are not
    // yet consumed, shifted so that the next slice sits at bits [SW-1:0].
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] carry_d;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;

    // Slice operands and the SW+1-bit slice sum of each stage.
    logic [SW-1:0]     sl_a_s [STAGES];
    logic [SW-1:0]     sl_b_s [STAGES];
    logic [SW:0]       full_s [STAGES];

    logic              adv_s;

    // The whole pipe advances unless a finished result is blocked at the
    // output. Bubbles are not collapsed.
    assign adv_s    = out_ready | ~valid_q[STAGES-1];
    assign in_ready = adv_s;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign sl_a_s[k]  = a[SW-1:0];
                assign sl_b_s[k]  = b[SW-1:0];
                assign full_s[k]  = {1'b0, sl_a_s[k]} + {1'b0, sl_b_s[k]}
                                  + {{SW{1'b0}}, cin};
                assign res_d[k]   = WIDTH'(full_s[k][SW-1:0]) << (WIDTH - SW);
                assign opa_d[k]   = a >> SW;
                assign opb_d[k]   = b >> SW;
                assign valid_d[k] = in_valid;
            end else begin : g_rest
                assign sl_a_s[k]  = opa_q[k-1][SW-1:0];
                assign sl_b_s[k]  = opb_q[k-1][SW-1:0];
                assign full_s[k]  = {1'b0, sl_a_s[k]} + {1'b0, sl_b_s[k]}
                                  + {{SW{1'b0}}, carry_q[k-1]};
                // New slice enters at the top; earlier slices shift down.
                assign res_d[k]   = (res_q[k-1] >> SW)
                                  | (WIDTH'(full_s[k][SW-1:0]) << (WIDTH - SW));
                assign opa_d[k]   = opa_q[k-1] >> SW;
                assign opb_d[k]   = opb_q[k-1] >> SW;
                assign valid_d[k] = valid_q[k-1];
            end
            assign carry_d[k] = full_s[k][SW];
        end
    endgenerate

    // Pipeline registers: all stages load together on advance, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= {STAGES{1'b0}};
            carry_q <= {STAGES{1'b0}};
            for (int i = 0; i < STAGES; i++) begin
                opa_q[i] <= {WIDTH{1'b0}};
                opb_q[i] <= {WIDTH{1'b0}};
                res_q[i] <= {WIDTH{1'b0}};
            end
        end else if (adv_s) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
        end
    end

    assign sum       = res_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign out_valid = valid_q[STAGES-1];

`ifdef PIPELINED_CARRY_ADDER_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // The final stage holds the top slice, so its MSBs are the operand MSBs.
    assign ovf_d = (sl_a_s[STAGES-1][SW-1] == sl_b_s[STAGES-1][SW-1])
                 & (full_s[STAGES-1][SW-1] != sl_a_s[STAGES-1][SW-1]);

    // Overflow flag register, moves with the result in the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv_s) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_carry_adder.sv
module tb_pipelined_carry_adder;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_pass;
    int n_total;

`ifdef PIPELINED_CARRY_ADDER_OVF_EN
    localparam logic [W+1:0] MASK = {(W+2){1'b1}};
`else
    localparam logic [W+1:0] MASK = {1'b0, {(W+1){1'b1}}};
    assign ovf = 1'b0;
`endif

    pipelined_carry_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
        .cout      (cout),
        .ovf       (ovf)
`else
        .cout      (cout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer addition; {ovf, cout, sum}
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c);
        longint u;
        longint s;
        logic [W:0] full;
        logic v;
        u = longint'(x) + longint'(y) + longint'(c);
        s = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        full = u[W:0];
        v = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
        return {v, full};
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return {W{1'b0}};
            1:       return {W{1'b1}};
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (S + 2) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #12;
        n_total++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL reset_hs: got ready/valid %b expected 10", {in_ready, out_valid});
        else n_pass++;
        n_total++;
        if ({ovf, cout, sum} !== '0) $display("FAIL reset_data: got %h expected 0", {ovf, cout, sum});
        else n_pass++;
        #6 rst_n = 1'b1;
        step();
        n_total++;
        if ({in_ready, out_valid, ovf, cout, sum} !== {1'b1, 1'b0, {(W+2){1'b0}}})
            $display("FAIL post_reset_idle: got %h expected %h", {in_ready, out_valid, ovf, cout, sum}, {2'b10, {(W+2){1'b0}}});
        else n_pass++;
    endtask

    task automatic test_single_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic c, input logic [W-1:0] es, input logic ec);
        out_ready = 1'b1;
        a = x; b = y; cin = c; in_valid = 1'b1;
        for (int cyc = 1; cyc <= S + 2; cyc++) begin
            step();
            in_valid = 1'b0;
            n_total++;
            if (out_valid !== (cyc == S)) $display("FAIL %s_latency: cycle %0d out_valid %b expected %b", name, cyc, out_valid, cyc == S);
            else n_pass++;
            if (cyc == S) begin
                n_total++;
                if ({cout, sum} !== {ec, es}) $display("FAIL %s_value: got %h expected %h", name, {cout, sum}, {ec, es});
                else n_pass++;
            end
        end
    endtask

    task automatic test_streaming();
        longint e;
        out_ready = 1'b1;
        for (int cyc = 0; cyc <= S + 11; cyc++) begin
            n_total++;
            if (out_valid !== (cyc >= S && cyc < S + 10)) $display("FAIL stream_valid: cycle %0d got %b", cyc, out_valid);
            else n_pass++;
            if (cyc >= S && cyc < S + 10) begin
                e = 3 * longint'(cyc - S) + longint'((cyc - S) % 2);
                n_total++;
                if ({cout, sum} !== {1'b0, W'(e)}) $display("FAIL stream_value: cycle %0d got %h expected %h", cyc, {cout, sum}, e);
                else n_pass++;
            end
            if (cyc < 10) begin
                in_valid = 1'b1; a = W'(cyc); b = W'(2 * cyc); cin = 1'(cyc % 2);
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [W+1:0] q[$];
        logic [W-1:0] oa[6];
        logic [W-1:0] ob[6];
        logic         oc[6];
        logic [W+1:0] last;
        logic         stall;
        int nxt, got, stalls;
        nxt = 0; got = 0; stalls = 0; stall = 1'b0; last = '0;
        for (int i = 0; i < 6; i++) begin
            oa[i] = pick_operand(); ob[i] = pick_operand(); oc[i] = 1'($urandom_range(0, 1));
        end
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 5 && cyc <= 8);
            if (nxt < 6) begin
                in_valid = 1'b1; a = oa[nxt]; b = ob[nxt]; cin = oc[nxt];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall) begin
                n_total++;
                if (!out_valid || (({ovf, cout, sum} & MASK) !== (last & MASK)))
                    $display("FAIL bp_stable: cycle %0d got %b/%h expected 1/%h", cyc, out_valid, {ovf, cout, sum}, last);
                else n_pass++;
            end
            if (out_valid && !out_ready) begin
                stalls++;
                n_total++;
                if (in_ready !== 1'b0) $display("FAIL bp_in_ready: cycle %0d got %b expected 0", cyc, in_ready);
                else n_pass++;
            end
            if (out_valid) begin
                n_total++;
                if (q.size() == 0) $display("FAIL bp_spurious: cycle %0d got %h expected none", cyc, {ovf, cout, sum});
                else if (({ovf, cout, sum} & MASK) !== (q[0] & MASK))
                    $display("FAIL bp_value: cycle %0d got %h expected %h", cyc, {ovf, cout, sum}, q[0]);
                else n_pass++;
            end
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front()); got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_add(a, b, cin)); nxt++;
            end
            stall = out_valid && !out_ready;
            last  = {ovf, cout, sum};
            step();
        end
        n_total++;
        if (got != 6 || q.size() != 0) $display("FAIL bp_count: got %0d retired expected 6 (left %0d)", got, q.size());
        else n_pass++;
        n_total++;
        if (stalls != 4) $display("FAIL bp_stall_cycles: got %0d expected 4", stalls);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = pick_operand(); b = pick_operand(); cin = 1'b1;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL rstmid_pre: got out_valid %b expected 1", out_valid);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({in_ready, out_valid, ovf, cout, sum} !== {1'b1, 1'b0, {(W+2){1'b0}}})
            $display("FAIL rstmid_clear: got %h expected %h", {in_ready, out_valid, ovf, cout, sum}, {2'b10, {(W+2){1'b0}}});
        else n_pass++;
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen++;
        end
        n_total++;
        if (seen != 0) $display("FAIL rstmid_stale: got %0d results expected 0", seen);
        else n_pass++;
    endtask

`ifdef PIPELINED_CARRY_ADDER_OVF_EN
    task automatic test_ovf();
        logic [W+1:0] expv[2];
        expv[0] = {1'b1, 1'b0, 16'h8000};
        expv[1] = {1'b1, 1'b1, 16'h0000};
        out_ready = 1'b1;
        for (int cyc = 0; cyc <= S + 2; cyc++) begin
            if (cyc >= S && cyc < S + 2) begin
                n_total++;
                if ({out_valid, ovf, cout, sum} !== {1'b1, expv[cyc - S]})
                    $display("FAIL ovf_value: cycle %0d got %h expected %h", cyc, {out_valid, ovf, cout, sum}, {1'b1, expv[cyc - S]});
                else n_pass++;
            end
            case (cyc)
                0:       begin in_valid = 1'b1; a = 16'h7FFF; b = 16'h0001; cin = 1'b0; end
                1:       begin in_valid = 1'b1; a = 16'h8000; b = 16'h8000; cin = 1'b0; end
                default: in_valid = 1'b0;
            endcase
            step();
        end
    endtask
`endif

    task automatic test_random();
        logic [W+1:0] q[$];
        logic [W+1:0] last;
        logic         stall;
        logic         hold;
        stall = 1'b0; hold = 1'b0; last = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            out_ready = ($urandom_range(0, 99) < 65);
            if (!hold) begin
                in_valid = ($urandom_range(0, 99) < 70);
                a = pick_operand(); b = pick_operand(); cin = 1'($urandom_range(0, 1));
            end
            #1;
            n_total++;
            if (in_ready !== (out_ready || !out_valid)) $display("FAIL rnd_in_ready: cycle %0d got %b", cyc, in_ready);
            else n_pass++;
            if (stall) begin
                n_total++;
                if (!out_valid || (({ovf, cout, sum} & MASK) !== (last & MASK)))
                    $display("FAIL rnd_stable: cycle %0d got %b/%h expected 1/%h", cyc, out_valid, {ovf, cout, sum}, last);
                else n_pass++;
            end
            if (out_valid) begin
                n_total++;
                if (q.size() == 0) $display("FAIL rnd_spurious: cycle %0d got %h expected none", cyc, {ovf, cout, sum});
                else if (({ovf, cout, sum} & MASK) !== (q[0] & MASK))
                    $display("FAIL rnd_value: cycle %0d got %h expected %h", cyc, {ovf, cout, sum}, q[0]);
                else n_pass++;
                if (out_ready && q.size() > 0) void'(q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(ref_add(a, b, cin));
            hold  = in_valid && !in_ready;
            stall = out_valid && !out_ready;
            last  = {ovf, cout, sum};
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4 * S && q.size() > 0; i++) begin
            if (out_valid) begin
                n_total++;
                if (({ovf, cout, sum} & MASK) !== (q[0] & MASK))
                    $display("FAIL rnd_drain: got %h expected %h", {ovf, cout, sum}, q[0]);
                else n_pass++;
                void'(q.pop_front());
            end
            step();
        end
        n_total++;
        if (q.size() != 0) $display("FAIL rnd_lost: got %0d undelivered expected 0", q.size());
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_single_op("basic", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
        flush();
        test_single_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        flush();
        test_streaming();
        flush();
        test_backpressure();
        flush();
        test_reset_mid();
        test_single_op("after_reset", 16'h8001, 16'h7FFF, 1'b0, 16'h0000, 1'b1);
        flush();
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
        test_ovf();
        flush();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipelined_carry_adder.md
Name: pipelined_carry_adder

Overview:
- Parametrised successor to the 4-bit ripple-carry adder: WIDTH-bit add with carry-in/carry-out, carry chain split into STAGES registered slices.
- Valid/ready handshake on input and output; one operation accepted per cycle at full throughput.
- Sits between operand-producing datapath blocks and result consumers that may apply backpressure.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; each stage adds one slice of SW = WIDTH/STAGES bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, cin valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A, unsigned/two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  sum, cout (and ovf) valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Single clock, one clock domain. Reset is asynchronous and active-low (rst_n). All flops clear on reset assertion without waiting for clk.
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0. All stage valid bits, slice registers and carry registers are 0.
- Global advance: adv = out_ready | ~out_valid. in_ready = adv (combinational; no dependency on in_valid). Input accepted when in_valid & in_ready.
- When adv=1, every stage register loads from the previous stage. Stage 0 loads from the inputs, with valid_0 = in_valid.
- When adv=0, all stage registers and valid bits hold.
- Bubbles are not collapsed: an invalid slot travels down the pipe like data.
- Stage k (0..STAGES-1) adds slice k: a[k*SW +: SW] + b[k*SW +: SW] + carry_k.
  - carry_0 = cin.
  - carry_k for k>0 = registered carry out of stage k-1.
  - Full SW+1-bit result: low SW bits to the slice result, MSB to the carry register.
- Operand skew: slices k+1..STAGES-1 are delayed through shift registers so each slice arrives at stage k together with its carry.
- Result de-skew: completed slices are delayed so all slices of one operation reach the output together.
- Latency: exactly STAGES cycles from accept to out_valid=1, with no backpressure.
- Output registers: sum is the concatenation of slice results; cout is the final-stage carry.
- out_valid = valid bit of the last stage. A result is retired on out_valid & out_ready.
- While out_valid=1 and out_ready=0, sum, cout and out_valid stay stable, and in_ready=0.
- Throughput: 1 result/cycle while out_ready is held high.
- Simultaneous accept and retire in the same cycle is allowed; no data is lost or duplicated.
- STAGES=1 degenerates to a registered WIDTH-bit adder with 1-cycle latency.
- Reset mid-operation: all in-flight operations are discarded and out_valid=0 immediately. The first accept after rst_n deasserts behaves as from a clean pipe.
- Wrap-around: sum is modulo 2^WIDTH; the overflow bit appears only on cout.

Optional Feature:
- Macro: PIPELINED_CARRY_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), the signed overflow flag: (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]).
  - Computed in the final stage from the delayed operand MSBs and travels with its result.
  - Reset value 0; held stable under backpressure like sum.
- Not defined: port ovf does not exist and no extra MSB delay flops are instantiated. All other behaviour is identical.

Test Plan:
- Basic latency (WIDTH=16, STAGES=4): accept a=0x1234, b=0x1111, cin=0 at cycle 0, out_ready=1 -> out_valid=1 at cycle 4 with sum=0x2345, cout=0.
- Full carry ripple across all stages: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1 after 4 cycles.
- Streaming: accept 10 back-to-back operations (a=i, b=2i, cin=i[0]) with out_ready=1 -> 10 consecutive results i+2i+i[0] on cycles 4..13, no gaps.
- Backpressure: stream 6 operations and hold out_ready=0 for cycles 5-8 -> in_ready=0 and sum/cout stable during the stall; all 6 results delivered in order afterwards, none dropped or duplicated.
- Reset mid-flight: accept 3 operations, pulse rst_n=0 asynchronously between edges -> out_valid=0 and sum=0 immediately; no stale result appears after reset release.
- OVF (macro defined): a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, ovf=1, cout=0. Then a=0x8000, b=0x8000 -> sum=0x0000, ovf=1, cout=1.
